// File: rtl/logic_shift_unit.sv
// Logic/shift unit: bitwise ops finish on the accepting edge; shifts step one bit per clock.
// Y and the C/V/N/Z flags are registered and held between completions.
module logic_shift_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [1:0] K_SHL = 2'b00;
  localparam logic [1:0] K_SHR = 2'b01;
  localparam logic [1:0] K_SAR = 2'b10;
  localparam logic [1:0] K_ROL = 2'b11;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [1:0]       kind_q, kind_d;
  logic             vacc_q, vacc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  logic [SW-1:0]    amt;
  logic             accept;
  logic [WIDTH:0]   step;

  // Returns {bit shifted out, new value} for a single one-bit step.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0] kind,
                                                input logic [WIDTH-1:0] v);
    logic [WIDTH:0] r;
    case (kind)
      K_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      K_SHR:   r = {v[0], 1'b0, v[WIDTH-1:1]};
      K_SAR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  assign amt    = B[SW-1:0];
  assign accept = (state_q == IDLE) && start;
  assign step   = shift_step(kind_q, work_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && OP[2] && (amt != '0)) state_d = SHIFT;
      SHIFT:   if (cnt_q == SW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    vacc_d = vacc_q;
    y_d    = y_q;
    c_d    = c_q;
    v_d    = v_q;
    done_d = 1'b0;
    if (accept) begin
      kind_d = OP[1:0];
      if (!OP[2]) begin
        y_d    = logic_op(OP[1:0], A, B);
        c_d    = 1'b0;
        v_d    = 1'b0;
        done_d = 1'b1;
      end else if (amt == '0) begin
        y_d    = A;
        c_d    = 1'b0;
        v_d    = 1'b0;
        done_d = 1'b1;
      end else begin
        work_d = A;
        cnt_d  = amt;
        vacc_d = 1'b0;
      end
    end else if (state_q == SHIFT) begin
      work_d = step[WIDTH-1:0];
      cnt_d  = cnt_q - SW'(1);
      // Overflow is sticky: any MSB change during a left shift flags it.
      vacc_d = vacc_q | ((kind_q == K_SHL) && (step[WIDTH-1] != work_q[WIDTH-1]));
      if (cnt_q == SW'(1)) begin
        y_d    = step[WIDTH-1:0];
        c_d    = step[WIDTH];
        v_d    = vacc_d;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      kind_q <= '0;
      vacc_q <= 1'b0;
      y_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      vacc_q <= vacc_d;
      y_q    <= y_d;
      c_q    <= c_d;
      v_q    <= v_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign Y    = y_q;
  assign C    = c_q;
  assign V    = v_q;
  assign N    = y_q[WIDTH-1];
  assign Z    = (y_q == '0);

endmodule
